// File: rtl/aes_dec_key_sched.sv
// aes_dec_key_sched: iterative AES-128 decrypt key scheduler streaming round keys 10..0 over valid/ready.
// Defining AES_EQINV_KEY_EN outputs InvMixColumns(key) for rounds 9..1 (equivalent inverse cipher).
module aes_dec_key_sched #(
   parameter int EXP_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         rk_last
);
   typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;
   // byte r holds Rcon[r]; bytes 0 and 11..15 are zero
   localparam logic [127:0] RCON = 128'h0000000000361b804020100804020100;
   state_t state, state_n;
   logic [127:0] key, key_n, fwd_key;
   logic [3:0] cnt, cnt_n;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] a2, a3, a12, v;
      a2 = gmul(a, a);
      a3 = gmul(a2, a);
      a12 = gmul(gmul(a3, a3), gmul(a3, a3));
      v = gmul(a12, a3);
      for (int i = 0; i < 4; i++) v = gmul(v, v);
      v = gmul(gmul(v, a12), a2);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subrot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [31:0] rcon(input logic [3:0] r);
      return {RCON[8*r +: 8], 24'h0};
   endfunction

   function automatic logic [127:0] fstep(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] w0, w1, w2;
      w0 = k[127:96] ^ subrot(k[31:0]) ^ rcon(r);
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      return {w0, w1, w2, k[31:0] ^ w2};
   endfunction

   function automatic logic [127:0] istep(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] p3;
      p3 = k[31:0] ^ k[63:32];
      return {k[127:96] ^ subrot(p3) ^ rcon(r), k[127:96] ^ k[95:64], k[95:64] ^ k[63:32], p3};
   endfunction

`ifdef AES_EQINV_KEY_EN
   function automatic logic [31:0] imix(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction
`endif

   always_comb begin
      fwd_key = key;
      for (int j = 0; j < EXP_PER_CYCLE; j++) fwd_key = fstep(fwd_key, cnt + 4'(j) + 4'd1);
      state_n = state;
      key_n = key;
      cnt_n = cnt;
      unique case (state)
         IDLE: if (key_load) begin
            state_n = EXPAND;
            key_n = key_in;
            cnt_n = 4'd0;
         end
         EXPAND: begin
            key_n = fwd_key;
            cnt_n = cnt + 4'(EXP_PER_CYCLE);
            state_n = (cnt_n == 4'd10) ? SERVE : EXPAND;
         end
         SERVE: if (rk_ready) begin
            state_n = (cnt == 4'd0) ? IDLE : SERVE;
            key_n = (cnt == 4'd0) ? key : istep(key, cnt);
            cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         key <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         key <= key_n;
         cnt <= cnt_n;
      end

   assign busy = state != IDLE;
   assign rk_valid = state == SERVE;
   assign rk_round = rk_valid ? cnt : 4'd0;
   assign rk_last = rk_valid && cnt == 4'd0;
`ifdef AES_EQINV_KEY_EN
   assign rk_data = !rk_valid ? '0 : (cnt == 4'd0 || cnt == 4'd10) ? key :
                    {imix(key[127:96]), imix(key[95:64]), imix(key[63:32]), imix(key[31:0])};
`else
   assign rk_data = rk_valid ? key : '0;
`endif
endmodule
